// File: rtl/stdp_weight_sched.sv
// Per-neuron STDP weight-update scheduler: snapshots the synapse case vectors on gamma and walks them one per clock through a shared saturating adder.
// Optional macro STDP_STOCH_EN gates search/backoff updates with a 16-bit LFSR.
module stdp_weight_sched #(
    parameter int NSYN  = 8,
    parameter int WBITS = 3,
    parameter int WINIT = 2 ** (WBITS - 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      grst,
    input  logic [4*NSYN-1:0]         cases_in,
    output logic [NSYN*WBITS-1:0]     weights,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(NSYN+1)-1:0] upd_cnt,
    output logic                      overrun
);
    localparam int CW = $clog2(NSYN + 1);
    localparam int PW = $clog2(NSYN);
    localparam logic [WBITS-1:0] WMAX = {WBITS{1'b1}};
    localparam logic [WBITS-1:0] WRST = WBITS'(WINIT);

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_t;

    state_t                     r_state;
    logic [NSYN-1:0][3:0]       r_snap;
    logic [NSYN-1:0][WBITS-1:0] r_wt;
    logic [PW-1:0]              r_ptr;
    logic [CW-1:0]              r_cnt;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_ovr;

    logic [3:0]                 w_case;
    logic [WBITS-1:0]           w_wcur;
    logic                       w_gate;
    logic signed [1:0]          w_step;

    // Priority bit0 > bit1 > bit2 > bit3 keeps illegal multi-hot inputs deterministic.
    function automatic logic signed [1:0] case_step(input logic [3:0] c, input logic gate);
        logic signed [1:0] d;
        if (c[0])      d = 2'sd1;
        else if (c[1]) d = -2'sd1;
        else if (c[2]) d = gate ? 2'sd1 : 2'sd0;
        else if (c[3]) d = gate ? -2'sd1 : 2'sd0;
        else           d = 2'sd0;
        return d;
    endfunction

    function automatic logic [WBITS-1:0] sat_step(input logic [WBITS-1:0] w, input logic signed [1:0] d);
        logic [WBITS-1:0] r;
        if (d == 2'sd1)       r = (w == WMAX) ? w : w + WBITS'(1);
        else if (d == -2'sd1) r = (w == '0) ? w : w - WBITS'(1);
        else                  r = w;
        return r;
    endfunction

`ifdef STDP_STOCH_EN
    logic [15:0] r_lfsr;

    // Fibonacci taps 16,14,13,11; free-running so gating is independent of scan phase.
    always_ff @(posedge clk) begin
        if (rst) r_lfsr <= 16'hACE1;
        else     r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end

    assign w_gate = (r_lfsr[1:0] == 2'b00);
`else
    assign w_gate = 1'b1;
`endif

    assign w_case = r_snap[r_ptr];
    assign w_wcur = r_wt[r_ptr];
    assign w_step = case_step(w_case, w_gate);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_snap  <= '0;
            r_wt    <= {NSYN{WRST}};
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (grst) begin
                        r_snap  <= cases_in;
                        r_ptr   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SCAN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    // A gamma arriving mid-scan is flagged but never restarts the walk.
                    if (grst) r_ovr <= 1'b1;
                    if (w_step != 2'sd0) begin
                        r_wt[r_ptr] <= sat_step(w_wcur, w_step);
                        r_cnt       <= r_cnt + CW'(1);
                    end
                    if (r_ptr == PW'(NSYN - 1)) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_ptr <= r_ptr + PW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign weights = r_wt;
    assign busy    = r_busy;
    assign done    = r_done;
    assign upd_cnt = r_cnt;
    assign overrun = r_ovr;

endmodule

// File: tb/tb_stdp_weight_sched.sv
// Randomised self-checking bench for stdp_weight_sched; expected weights come from a per-scan arithmetic model.
// Honours STDP_STOCH_EN the same way as the design build.
module tb_stdp_weight_sched;
    localparam int NSYN  = 8;
    localparam int WBITS = 3;
    localparam int WINIT = 4;
    localparam int WMAX  = 7;
    localparam int CW    = $clog2(NSYN + 1);

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  grst = 1'b0;
    logic [4*NSYN-1:0]     cases_in = '0;
    logic [NSYN*WBITS-1:0] weights;
    logic                  busy;
    logic                  done;
    logic [CW-1:0]         upd_cnt;
    logic                  overrun;

    int n_chk = 0;
    int n_err = 0;
    int mw[NSYN];
    int mcnt;
    int movr;
    logic [15:0] m_lfsr;

    stdp_weight_sched #(.NSYN(NSYN), .WBITS(WBITS), .WINIT(WINIT)) dut (
        .clk(clk), .rst(rst), .grst(grst), .cases_in(cases_in),
        .weights(weights), .busy(busy), .done(done),
        .upd_cnt(upd_cnt), .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Reference generator state: the value it holds during each clock cycle.
    always @(posedge clk) m_lfsr <= rst ? 16'hACE1 : lfsr_next(m_lfsr);

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int step_of(input logic [3:0] c, input logic [15:0] lf);
        bit g;
`ifdef STDP_STOCH_EN
        g = (lf[1:0] == 2'b00);
`else
        g = 1'b1;
`endif
        if (c[0]) return 1;
        if (c[1]) return -1;
        if (c[2]) return g ? 1 : 0;
        if (c[3]) return g ? -1 : 0;
        return 0;
    endfunction

    function automatic logic [NSYN*WBITS-1:0] packw();
        logic [NSYN*WBITS-1:0] v;
        for (int i = 0; i < NSYN; i++) v[i*WBITS +: WBITS] = WBITS'(mw[i]);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NSYN; i++) mw[i] = WINIT;
        mcnt = 0;
        movr = 0;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst  = 1'b1;
        grst = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One full gamma scan; extra>0 injects a second gamma in cycle T+extra, now=1 issues grst in the current (DONE) cycle.
    task automatic do_scan(input logic [4*NSYN-1:0] cs, input int extra, input bit now);
        logic [15:0] lf;
        int d;
        if (!now) begin
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
        end
        cases_in = cs;
        grst     = 1'b1;
        lf       = m_lfsr;
        mcnt     = 0;
        for (int k = 0; k < NSYN; k++) begin
            @(negedge clk);
            lf       = lfsr_next(lf);
            grst     = (k + 1 == extra);
            cases_in = $urandom();
            if (k + 1 == extra) movr = 1;
            chk("scan_busy", busy, 1);
            chk("scan_done", done, 0);
            chk("scan_weights", weights, packw());
            d = step_of(cs[4*k +: 4], lf);
            if (d != 0) begin
                mcnt++;
                mw[k] = mw[k] + d;
                if (mw[k] > WMAX) mw[k] = WMAX;
                if (mw[k] < 0) mw[k] = 0;
            end
        end
        @(negedge clk);
        grst = 1'b0;
        chk("end_done", done, 1);
        chk("end_busy", busy, 0);
        chk("end_weights", weights, packw());
        chk("end_upd_cnt", upd_cnt, mcnt);
        chk("end_overrun", overrun, movr);
    endtask

    function automatic logic [3:0] rand_case();
        case ($urandom_range(0, 5))
            0: return 4'h0;
            1: return 4'h1;
            2: return 4'h2;
            3: return 4'h4;
            4: return 4'h8;
            default: return 4'($urandom());
        endcase
    endfunction

    initial begin
        logic [4*NSYN-1:0] cs;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_weights", weights, {NSYN{3'd4}});
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_upd_cnt", upd_cnt, 0);

        do_scan(32'h0000_8421, 0, 1'b0);

        do_reset(2);
        repeat (5) do_scan(32'h1111_1111, 0, 1'b0);
        chk("sat_high", weights, {NSYN{3'd7}});
        repeat (8) do_scan(32'h8888_8888, 0, 1'b0);

        do_reset(2);
        do_scan($urandom(), 4, 1'b0);
        do_scan($urandom(), 0, 1'b1);
        chk("overrun_sticky", overrun, 1);

        do_reset(2);
        do_scan(32'h0060_0000, 0, 1'b0);
        chk("multihot_w5", weights[5*WBITS +: WBITS], 3);

        @(negedge clk);
        cases_in = 32'h1111_1111;
        grst     = 1'b1;
        @(negedge clk);
        grst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("midrst_weights", weights, {NSYN{3'd4}});
        chk("midrst_busy", busy, 0);
        chk("midrst_cnt", upd_cnt, 0);
        chk("midrst_overrun", overrun, 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("midrst_nodone", done, 0);
        end

        repeat (10) do_scan(32'h4444_4444, 0, 1'b0);

        do_reset(2);
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < NSYN; i++) cs[4*i +: 4] = rand_case();
            do_scan(cs, ($urandom_range(0, 3) == 0) ? $urandom_range(1, NSYN - 1) : 0,
                    ($urandom_range(0, 2) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
